// File: rtl/thee_busdly_sched.sv
// Clocked per-bit skew scheduler: draws a reproducible delay per bus bit from a
// seedable Galois LFSR and releases each bit of the accepted word at its cycle.
module thee_busdly_sched #(
    parameter int          WIDTH   = 8,
    parameter int          MAX_DLY = 7,
    parameter int          CNT_W   = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1,
    parameter logic [31:0] SEED    = 32'hACE1_2D5F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [31:0]      seed_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] bus_out,
    output logic             busy,
    output logic             settled
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0]      MASK     = 32'h8020_0003;
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_DLY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] maxd;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] dly [WIDTH];
    logic             accept;

    assign accept = (state == IDLE) && in_valid;

    // Raw codes above MAX_DLY fold back into range so every code maps to a legal delay.
    always_comb begin
        lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
        r        = lfsr[CNT_W-1:0];
        d        = (r > MAX_C) ? (r - MAX_C - CNT_W'(1)) : r;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && en)     state_nxt = DRAW;
            DRAW: if (idx == LAST_IDX)  state_nxt = RUN;
            RUN:  if (cnt == maxd)      state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out <= '0;
            lfsr    <= SEED;
            cnt     <= '0;
            idx     <= '0;
            maxd    <= '0;
            data_q  <= '0;
            for (int i = 0; i < WIDTH; i++) dly[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The seed lands before DRAW, so a same-edge accept draws from it.
                    if (seed_load) lfsr <= (seed_val == 32'd0) ? SEED : seed_val;
                    if (accept) begin
                        data_q <= in_data;
                        if (en) begin
                            idx  <= '0;
                            maxd <= '0;
                        end else begin
                            bus_out <= in_data;
                        end
                    end
                end
                DRAW: begin
                    dly[idx] <= d;
                    if (d > maxd) maxd <= d;
                    lfsr <= lfsr_nxt;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        cnt <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WIDTH; i++)
                        if (dly[i] == cnt) bus_out[i] <= data_q[i];
                    if (cnt != maxd) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign settled  = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_thee_busdly_sched.sv
// Bench for thee_busdly_sched: vector table for bypass, hand sequences for latency,
// seeding and reset, and randomized words against a per-bit release-time model.
module tb_thee_busdly_sched;

    localparam int          W    = 8;
    localparam int          MD   = 7;
    localparam logic [31:0] SEED = 32'hACE1_2D5F;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         seed_load = 1'b0;
    logic [31:0]  seed_val = 32'd0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, busy, settled;
    logic [W-1:0] bus_out;

    logic         in_valid1 = 1'b0;
    logic [W-1:0] in_data1 = '0;
    logic         in_ready1, busy1, settled1;
    logic [W-1:0] bus_out1;

    int           total = 0;
    int           bad = 0;
    logic [31:0]  model_lfsr = SEED;
    logic [W-1:0] model_bus = '0;
    int           obs_rise [W];
    int           ref_rise [W];

    typedef struct {
        logic         v;
        logic [W-1:0] data;
        logic [W-1:0] exp_bus;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    thee_busdly_sched #(.WIDTH(W), .MAX_DLY(MD), .SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_val(seed_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bus_out(bus_out), .busy(busy), .settled(settled)
    );

    thee_busdly_sched #(.WIDTH(W), .MAX_DLY(0), .SEED(SEED)) u_dut0 (
        .clk(clk), .rst(rst), .en(1'b1), .seed_load(1'b0), .seed_val(32'd0),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .bus_out(bus_out1), .busy(busy1), .settled(settled1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic int map_dly(input logic [31:0] s, input int md);
        int cw = 1;
        int r;
        while ((1 << cw) < md + 1) cw++;
        r = int'(s & ((32'd1 << cw) - 32'd1));
        return (r <= md) ? r : r - (md + 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; seed_load = 1'b0; in_valid1 = 1'b0; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_lfsr = SEED;
        model_bus  = '0;
        check("reset_out", {bus_out, busy, in_ready, settled}, {8'h00, 1'b0, 1'b1, 1'b1});
        check("reset_out0", {bus_out1, busy1, in_ready1, settled1}, {8'h00, 1'b0, 1'b1, 1'b1});
    endtask

    // Called at a negedge with the DUT idle. Bit i of the new word must appear
    // W+1+d_i cycles after the accept edge; abort_at injects a one-edge reset.
    task automatic send_skew(input logic [W-1:0] data, input bit with_seed,
                             input logic [31:0] sv, input bit disturb, input int abort_at);
        int           dd [W];
        int           maxd;
        int           busy_cnt;
        logic [31:0]  s;
        logic [W-1:0] old;
        logic [W-1:0] exp;
        if (with_seed) model_lfsr = (sv == 32'd0) ? SEED : sv;
        s = model_lfsr;
        maxd = 0;
        for (int i = 0; i < W; i++) begin
            dd[i] = map_dly(s, MD);
            if (dd[i] > maxd) maxd = dd[i];
            s = step(s);
            obs_rise[i] = -1;
        end
        old = model_bus;
        busy_cnt = 0;
        check("idle_before_accept", {in_ready, settled, busy}, {1'b1, 1'b1, 1'b0});
        seed_load = with_seed; seed_val = sv; in_valid = 1'b1; in_data = data; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; seed_load = 1'b0;
        for (int t = 0; t <= W + 1 + maxd; t++) begin
            if (t == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0; seed_load = 1'b0; en = 1'b1;
                check("abort_out", {bus_out, busy, in_ready, settled}, {8'h00, 1'b0, 1'b1, 1'b1});
                model_lfsr = SEED;
                model_bus  = '0;
                return;
            end
            for (int i = 0; i < W; i++)
                exp[i] = (t >= W + 1 + dd[i]) ? data[i] : old[i];
            check("skew_cycle", {bus_out, busy, in_ready, settled},
                  {exp, (t <= W + maxd), (t > W + maxd), (t > W + maxd)});
            if (busy) busy_cnt++;
            for (int i = 0; i < W; i++)
                if (obs_rise[i] < 0 && bus_out[i] !== old[i]) obs_rise[i] = t;
            if (disturb) begin
                if (t == 2) begin seed_load = 1'b1; seed_val = $urandom; end
                if (t == 3) seed_load = 1'b0;
                if (t == W) en = 1'b0;
            end
            if (t < W + 1 + maxd) @(negedge clk);
        end
        en = 1'b1; seed_load = 1'b0;
        check("busy_len", busy_cnt, W + 1 + maxd);
        model_lfsr = s;
        model_bus  = data;
    endtask

    task automatic bypass_word(input logic [W-1:0] data);
        en = 1'b0; in_valid = 1'b1; in_data = data;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; en = 1'b1;
        model_bus = data;
        check("bypass_rand", {bus_out, busy, in_ready}, {model_bus, 1'b0, 1'b1});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [W-1:0] e;
        tbl[0] = '{1'b1, 8'h01, 8'h01};
        tbl[1] = '{1'b1, 8'h02, 8'h02};
        tbl[2] = '{1'b1, 8'h03, 8'h03};
        tbl[3] = '{1'b1, 8'h04, 8'h04};
        tbl[4] = '{1'b0, 8'h55, 8'h04};
        tbl[5] = '{1'b1, 8'h3C, 8'h3C};

        do_reset();

        // MAX_DLY=0 instance: all bits land together 9 edges after accept
        in_valid1 = 1'b1; in_data1 = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        busy_cnt = 0;
        for (int t = 0; t <= 9; t++) begin
            e = (t >= 9) ? 8'hA5 : 8'h00;
            check("minlat", {bus_out1, busy1, settled1}, {e, (t < 9), (t >= 9)});
            if (busy1) busy_cnt++;
            if (t < 9) @(negedge clk);
        end
        check("minlat_busy_len", busy_cnt, 9);

        send_skew(8'h00, 1'b0, 32'd0, 1'b0, -1);
        send_skew(8'hFF, 1'b0, 32'd0, 1'b0, -1);

        do_reset();
        send_skew(8'hFF, 1'b1, 32'h1234_5678, 1'b0, -1);
        ref_rise = obs_rise;
        do_reset();
        send_skew(8'hFF, 1'b1, 32'h1234_5678, 1'b0, -1);
        for (int i = 0; i < W; i++) check("seed_repeat", obs_rise[i], ref_rise[i]);

        do_reset();
        send_skew(8'hFF, 1'b0, 32'd0, 1'b0, -1);
        ref_rise = obs_rise;
        do_reset();
        send_skew(8'hFF, 1'b1, 32'd0, 1'b0, -1);
        for (int i = 0; i < W; i++) check("seed_zero", obs_rise[i], ref_rise[i]);

        en = 1'b0;
        for (int n = 0; n < 6; n++) begin
            in_valid = tbl[n].v; in_data = tbl[n].data;
            @(posedge clk);
            @(negedge clk);
            check("bypass_tbl", {bus_out, in_ready, busy}, {tbl[n].exp_bus, 1'b1, 1'b0});
            model_bus = tbl[n].exp_bus;
        end
        in_valid = 1'b0; en = 1'b1;
        send_skew(8'h5A, 1'b0, 32'd0, 1'b0, -1);

        send_skew(8'hFF, 1'b0, 32'd0, 1'b0, W + 3);
        send_skew(8'hFF, 1'b0, 32'd0, 1'b0, -1);

        send_skew(8'hC3, 1'b0, 32'd0, 1'b1, -1);
        send_skew(8'h3C, 1'b0, 32'd0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] rd;
            rd = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bypass_word(rd);
            end else begin
                send_skew(rd, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom,
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W + 8)) : -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thee_busdly_sched.md
# thee_busdly_sched

Cycle-based skew scheduler for the random bus-delay models in the verification environment. It accepts one bus word at a time over a valid/ready handshake, draws a pseudo-random per-bit delay in clock cycles from a seedable LFSR, and releases each output bit at its scheduled cycle. The draw is deterministic and reproducible from the seed, replacing time-based `#delay` skew where a clocked, repeatable skew pattern is required.

## Interface
- `WIDTH`, 8: bus width in bits, ≥1.
- `MAX_DLY`, 7: maximum per-bit delay in cycles, ≥0.
- `CNT_W`, `$clog2(MAX_DLY+1)` (min 1): width of the delay codes and run counter.
- `SEED`, 32'hACE1_2D5F: LFSR reset value. Must be non-zero.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: 1 = random skew; 0 = bypass with zero delay.
- `seed_load` input 1: load `seed_val` into the LFSR. Honoured only in IDLE.
- `seed_val` input 32: new seed. A value of 0 loads `SEED` instead.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a word. High only in IDLE.
- `in_data` input WIDTH: word to be skewed onto the bus.
- `bus_out` output WIDTH: skewed bus, registered.
- `busy` output 1: high in DRAW and RUN.
- `settled` output 1: high in IDLE. Means `bus_out` equals the last accepted word.

## Operation
- **LFSR:** 32-bit Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003. Shift right; when bit 0 is 1, XOR the mask in. Advances only in DRAW, one step per cycle.
- **Delay mapping:**
  - `r = lfsr[CNT_W-1:0]`.
  - `d = r` if `r ≤ MAX_DLY`, else `r-(MAX_DLY+1)`.
  - `d` is always in `0..MAX_DLY`.
  - If `MAX_DLY=0`, every `d` is 0.
- **FSM states:** IDLE, DRAW, RUN.
- **IDLE:**
  - Accept when `in_valid && in_ready`; latch `in_data` into `data_q`.
  - If `en=1`: go to DRAW with `idx=0`, `maxd=0`.
  - If `en=0`: `bus_out <= in_data` on the accept edge and stay in IDLE.
  - If `seed_load` and accept occur on the same edge, the seed load takes effect first and the draw uses the new seed.
- **DRAW:** one edge per bit, WIDTH edges total. Each edge:
  - `dly[idx] <= d` (from the current LFSR value).
  - `maxd <= max(maxd, d)`.
  - LFSR advances.
  - `idx++`.
  - On `idx=WIDTH-1`: go to RUN with `cnt=0`.
- **RUN:** each edge:
  - Every bit `i` with `dly[i]==cnt` gets `bus_out[i] <= data_q[i]`. Bits whose value is unchanged are still scheduled, with no visible effect.
  - If `cnt==maxd`: go to IDLE. Otherwise `cnt++`.
- `en` is sampled only on the accept edge. Changes during DRAW or RUN have no effect on the word in flight.
- `seed_load` outside IDLE is ignored.
- **Reset, including mid-DRAW/RUN:**
  - State returns to IDLE and the word in flight is discarded.
  - Reset values: `bus_out=0`, LFSR=`SEED`, `cnt=0`, `idx=0`, `maxd=0`, `dly=0`.
  - Output levels after the reset edge: `in_ready=1`, `settled=1`, `busy=0`.

## Timing
- Accept on edge k with `en=1`:
  - DRAW occupies edges k+1..k+WIDTH.
  - RUN occupies edges k+WIDTH+1..k+WIDTH+1+maxd.
- Bit i is visible after edge k+WIDTH+1+d_i.
- `in_ready`/`settled` reassert after edge k+WIDTH+1+maxd.
- Busy window: WIDTH+1+maxd cycles. Maximum is WIDTH+1+MAX_DLY.
- Bypass (`en=0`): `bus_out` updates after the accept edge; `in_ready` stays high, so back-to-back accepts occur every cycle.
- Holding `in_valid` high with `en=1`: the next accept happens on the first edge where `in_ready=1`, i.e. one cycle after `settled` rises. There are no bubbles beyond that.
- Outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.

## Test plan
- **Minimal latency:**
  - Setup: `MAX_DLY=0`, WIDTH=8, `en=1`, accept 8'hA5 at edge k.
  - Required: `bus_out=8'hA5` after edge k+9 with all bits changing together; `settled` rises after edge k+9; `busy` is high for exactly 9 cycles.
- **Skew spread:**
  - Setup: `MAX_DLY=7`, `SEED` default, accept 8'h00 and then 8'hFF.
  - Required: each bit rises after edge k+9+d_i, where d_i matches a reference LFSR model; the busy length equals 9+max(d_i).
- **Seed determinism:**
  - Setup: `seed_load` with 32'h1234_5678, send 8'hFF; reset; `seed_load` with the same value, send 8'hFF again.
  - Required: identical per-bit rise cycles. `seed_val=0` must reproduce the `SEED` sequence.
- **Bypass:**
  - Setup: `en=0`, `in_valid` held for 4 cycles with data 01, 02, 03, 04.
  - Required: `bus_out` follows one cycle later, one word per cycle; `in_ready` constantly 1; LFSR unchanged.
- **Reset mid-RUN:**
  - Setup: assert `rst` for one edge while some bits have already updated toward 8'hFF.
  - Required: `bus_out=0`, `in_ready=1`, `busy=0` after that edge; the next draw matches a fresh `SEED` sequence.
- **Ignored controls:**
  - Setup: pulse `seed_load` during DRAW and toggle `en` during RUN.
  - Required: the in-flight schedule is unchanged and the following word uses the unmodified LFSR sequence.
